// File: rtl/hit_resolver.sv
// Frame-rate hit arbiter: resolves strikes between two players and tracks health, hitstun and the match result.
// Optional guard support is compiled in with `define HIT_RESOLVER_BLOCK_EN.
`timescale 1ns/1ps
module hit_resolver #(
  parameter int POS_WIDTH      = 10,
  parameter int HEALTH_MAX     = 100,
  parameter int HIT_RANGE_X    = 48,
  parameter int HIT_RANGE_Y    = 64,
  parameter int ACT_START      = 4,
  parameter int ACT_END        = 9,
  parameter int DMG_A1         = 8,
  parameter int DMG_A2         = 12,
  parameter int HITSTUN_FRAMES = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SCEN,
  input  logic [POS_WIDTH-1:0] p1_pos_x,
  input  logic [POS_WIDTH-1:0] p2_pos_x,
  input  logic [POS_WIDTH-1:0] p1_pos_y,
  input  logic [POS_WIDTH-1:0] p2_pos_y,
  input  logic                 p1_face_right,
  input  logic                 p2_face_right,
  input  logic                 p1_attack_active,
  input  logic                 p2_attack_active,
  input  logic [1:0]           p1_attack_type,
  input  logic [1:0]           p2_attack_type,
  input  logic [5:0]           p1_attack_frame,
  input  logic [5:0]           p2_attack_frame,
  input  logic                 p1_block,
  input  logic                 p2_block,
  output logic                 p1_hitstun_active,
  output logic                 p2_hitstun_active,
  output logic [7:0]           p1_health,
  output logic [7:0]           p2_health,
  output logic                 p1_hit_pulse,
  output logic                 p2_hit_pulse,
  output logic                 game_over,
  output logic [1:0]           winner
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HITSTUN = 2'd1, ST_KO = 2'd2} def_state_e;

  localparam int CW = $clog2(HITSTUN_FRAMES + 1);
  localparam logic [CW-1:0]      STUN_FULL = CW'(HITSTUN_FRAMES);
  localparam logic [CW-1:0]      STUN_BLK  = CW'(HITSTUN_FRAMES >> 1);
  localparam logic [7:0]         DMG1      = 8'(DMG_A1);
  localparam logic [7:0]         DMG2      = 8'(DMG_A2);
  localparam logic [7:0]         HMAX      = 8'(HEALTH_MAX);
  localparam logic [5:0]         ACT_S     = 6'(ACT_START);
  localparam logic [5:0]         ACT_E     = 6'(ACT_END);
  localparam logic [POS_WIDTH:0] RANGE_X   = (POS_WIDTH+1)'(HIT_RANGE_X);
  localparam logic [POS_WIDTH:0] RANGE_Y   = (POS_WIDTH+1)'(HIT_RANGE_Y);

  typedef struct packed {
    def_state_e    st;
    logic [CW-1:0] cnt;
    logic [7:0]    health;
  } def_t;

  def_t       p1_q, p1_d, p2_q, p2_d;
  logic       p1_tok_q, p1_tok_d, p2_tok_q, p2_tok_d;
  logic       p1_pulse_q, p1_pulse_d, p2_pulse_q, p2_pulse_d;
  logic       game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;
  logic       p1_blk, p2_blk;
  logic       hit_on_p1, hit_on_p2;
  logic       ko_p1, ko_p2;

`ifdef HIT_RESOLVER_BLOCK_EN
  assign p1_blk = p1_block;
  assign p2_blk = p2_block;
`else
  logic unused_block;
  assign p1_blk       = 1'b0;
  assign p2_blk       = 1'b0;
  assign unused_block = p1_block ^ p2_block;
`endif

  function automatic logic [POS_WIDTH:0] abs_diff(input logic [POS_WIDTH-1:0] a,
                                                  input logic [POS_WIDTH-1:0] b);
    logic [POS_WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[POS_WIDTH] ? ({1'b0, b} - {1'b0, a}) : d;
  endfunction

  // Attacker-side qualification; the defender's IDLE check is applied by the caller.
  function automatic logic strike(input logic active, input logic [1:0] atype,
                                  input logic [5:0] frame, input logic tok,
                                  input logic face_right,
                                  input logic [POS_WIDTH-1:0] ax, input logic [POS_WIDTH-1:0] ay,
                                  input logic [POS_WIDTH-1:0] dx, input logic [POS_WIDTH-1:0] dy);
    logic facing_ok;
    facing_ok = face_right ? (dx >= ax) : (dx <= ax);
    return active && (atype == 2'd1 || atype == 2'd2) && (frame >= ACT_S) &&
           (frame <= ACT_E) && !tok && facing_ok &&
           (abs_diff(ax, dx) <= RANGE_X) && (abs_diff(ay, dy) <= RANGE_Y);
  endfunction

  function automatic def_t def_next(input def_t cur, input logic hit,
                                    input logic [1:0] atype, input logic blk, input logic scen);
    def_t       nxt;
    logic [7:0] dmg;
    nxt = cur;
    dmg = (atype == 2'd1) ? DMG1 : DMG2;
    if (blk) dmg = dmg >> 2;
    if (hit) begin
      nxt.health = (cur.health > dmg) ? (cur.health - dmg) : 8'd0;
      if (nxt.health == 8'd0) begin
        nxt.st  = ST_KO;
        nxt.cnt = '0;
      end else begin
        nxt.st  = ST_HITSTUN;
        nxt.cnt = blk ? STUN_BLK : STUN_FULL;
      end
    end else if (scen && cur.st == ST_HITSTUN) begin
      nxt.cnt = cur.cnt - 1'b1;
      if (cur.cnt == CW'(1)) nxt.st = ST_IDLE;
    end
    return nxt;
  endfunction

  assign hit_on_p2 = SCEN && !game_over_q && (p2_q.st == ST_IDLE) &&
                     strike(p1_attack_active, p1_attack_type, p1_attack_frame, p1_tok_q,
                            p1_face_right, p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y);
  assign hit_on_p1 = SCEN && !game_over_q && (p1_q.st == ST_IDLE) &&
                     strike(p2_attack_active, p2_attack_type, p2_attack_frame, p2_tok_q,
                            p2_face_right, p2_pos_x, p2_pos_y, p1_pos_x, p1_pos_y);

  always_comb begin
    p1_d        = def_next(p1_q, hit_on_p1, p2_attack_type, p1_blk, SCEN);
    p2_d        = def_next(p2_q, hit_on_p2, p1_attack_type, p2_blk, SCEN);
    p1_tok_d    = p1_tok_q;
    p2_tok_d    = p2_tok_q;
    p1_pulse_d  = hit_on_p1;
    p2_pulse_d  = hit_on_p2;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    ko_p1       = hit_on_p1 && (p1_d.st == ST_KO);
    ko_p2       = hit_on_p2 && (p2_d.st == ST_KO);
    // Token holds through the whole attack so one swing lands at most once.
    if (SCEN) begin
      p1_tok_d = hit_on_p2 | (p1_attack_active & p1_tok_q);
      p2_tok_d = hit_on_p1 | (p2_attack_active & p2_tok_q);
    end
    if (ko_p1 || ko_p2) begin
      game_over_d = 1'b1;
      winner_d    = {ko_p1, ko_p2};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_q        <= '{st: ST_IDLE, cnt: '0, health: HMAX};
      p2_q        <= '{st: ST_IDLE, cnt: '0, health: HMAX};
      p1_tok_q    <= 1'b0;
      p2_tok_q    <= 1'b0;
      p1_pulse_q  <= 1'b0;
      p2_pulse_q  <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
    end else begin
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p1_tok_q    <= p1_tok_d;
      p2_tok_q    <= p2_tok_d;
      p1_pulse_q  <= p1_pulse_d;
      p2_pulse_q  <= p2_pulse_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign p1_hitstun_active = (p1_q.st != ST_IDLE);
  assign p2_hitstun_active = (p2_q.st != ST_IDLE);
  assign p1_health         = p1_q.health;
  assign p2_health         = p2_q.health;
  assign p1_hit_pulse      = p1_pulse_q;
  assign p2_hit_pulse      = p2_pulse_q;
  assign game_over         = game_over_q;
  assign winner            = winner_q;

endmodule

// File: tb/tb_hit_resolver.sv
// Directed bench for hit_resolver: a frame-level reference model pushes expected outputs to a queue,
// which are popped and checked against the DUT after each SCEN edge and after each pulse-clear edge.
`timescale 1ns/1ps
module tb_hit_resolver;
  localparam int W = 23;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scen = 1'b0;
  logic [9:0] px[2], py[2];
  logic       fr[2], act[2], blk[2];
  logic [1:0] typ[2];
  logic [5:0] frm[2];

  logic       p1_hitstun_active, p2_hitstun_active;
  logic [7:0] p1_health, p2_health;
  logic       p1_hit_pulse, p2_hit_pulse;
  logic       game_over;
  logic [1:0] winner;

  always #5 clk = ~clk;

  hit_resolver dut (
    .clk(clk), .reset(reset), .SCEN(scen),
    .p1_pos_x(px[0]), .p2_pos_x(px[1]), .p1_pos_y(py[0]), .p2_pos_y(py[1]),
    .p1_face_right(fr[0]), .p2_face_right(fr[1]),
    .p1_attack_active(act[0]), .p2_attack_active(act[1]),
    .p1_attack_type(typ[0]), .p2_attack_type(typ[1]),
    .p1_attack_frame(frm[0]), .p2_attack_frame(frm[1]),
    .p1_block(blk[0]), .p2_block(blk[1]),
    .p1_hitstun_active(p1_hitstun_active), .p2_hitstun_active(p2_hitstun_active),
    .p1_health(p1_health), .p2_health(p2_health),
    .p1_hit_pulse(p1_hit_pulse), .p2_hit_pulse(p2_hit_pulse),
    .game_over(game_over), .winner(winner)
  );

  logic [W-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int stun_seen;
  int pulses[2];

  // Reference model state: st 0 idle, 1 hitstun, 2 KO
  int m_h[2], m_cnt[2], m_st[2], m_win;
  bit m_tok[2], m_pulse[2], m_go;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [W-1:0] model_vec();
    return {8'(m_h[0]), 8'(m_h[1]), m_st[0] != 0, m_st[1] != 0,
            m_pulse[0], m_pulse[1], m_go, 2'(m_win)};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {p1_health, p2_health, p1_hitstun_active, p2_hitstun_active,
            p1_hit_pulse, p2_hit_pulse, game_over, winner};
  endfunction

  task automatic model_reset();
    m_h = '{100, 100}; m_cnt = '{0, 0}; m_st = '{0, 0};
    m_tok = '{0, 0}; m_pulse = '{0, 0}; m_go = 0; m_win = 0;
  endtask

  task automatic model_scen();
    bit hit[2];
    bit ko[2];
    for (int d = 0; d < 2; d++) begin
      int a;
      bit face_ok;
      a = 1 - d;
      face_ok = fr[a] ? (px[d] >= px[a]) : (px[d] <= px[a]);
      hit[d] = !m_go && m_st[d] == 0 && act[a] && (typ[a] == 2'd1 || typ[a] == 2'd2) &&
               frm[a] >= 6'd4 && frm[a] <= 6'd9 && !m_tok[a] && face_ok &&
               iabs(int'(px[a]) - int'(px[d])) <= 48 && iabs(int'(py[a]) - int'(py[d])) <= 64;
    end
    for (int d = 0; d < 2; d++) begin
      ko[d] = 0;
      if (hit[d]) begin
        int dmg, stun;
        dmg  = (typ[1-d] == 2'd1) ? 8 : 12;
        stun = 20;
`ifdef HIT_RESOLVER_BLOCK_EN
        if (blk[d]) begin dmg = dmg / 4; stun = 10; end
`endif
        m_h[d] = (m_h[d] > dmg) ? m_h[d] - dmg : 0;
        if (m_h[d] == 0) begin m_st[d] = 2; ko[d] = 1; end
        else begin m_st[d] = 1; m_cnt[d] = stun; end
      end else if (m_st[d] == 1) begin
        m_cnt[d]--;
        if (m_cnt[d] == 0) m_st[d] = 0;
      end
      m_pulse[d] = hit[d];
    end
    for (int a = 0; a < 2; a++) begin
      if (hit[1-a]) m_tok[a] = 1;
      else if (!act[a]) m_tok[a] = 0;
    end
    if (ko[0] || ko[1]) begin
      m_go  = 1;
      m_win = (ko[0] && ko[1]) ? 3 : (ko[1] ? 1 : 2);
    end
  endtask

  task automatic check_sb(input string tag);
    logic [W-1:0] obs, exp;
    obs = dut_vec();
    exp = exp_q.pop_front();
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame: SCEN for one clock, then one clock with SCEN low so the pulse clear is checked.
  task automatic frame();
    scen = 1'b1;
    model_scen();
    exp_q.push_back(model_vec());
    @(negedge clk);
    scen = 1'b0;
    if (p2_hitstun_active) stun_seen++;
    pulses[0] += int'(p1_hit_pulse);
    pulses[1] += int'(p2_hit_pulse);
    check_sb("scen_edge");
    m_pulse = '{0, 0};
    exp_q.push_back(model_vec());
    @(negedge clk);
    check_sb("pulse_clear");
  endtask

  task automatic run(input int n);
    repeat (n) frame();
  endtask

  // P1 attacks through frames lo..hi, then one idle frame to release the token.
  task automatic sweep(input int lo, input int hi, input logic [1:0] t);
    act[0] = 1'b1;
    typ[0] = t;
    for (int f = lo; f <= hi; f++) begin
      frm[0] = 6'(f);
      frame();
    end
    act[0] = 1'b0;
    frame();
  endtask

  task automatic trade(input logic [1:0] t);
    act = '{1, 1}; typ = '{t, t}; frm = '{6'd5, 6'd5};
    frame();
    act = '{0, 0};
    run(21);
  endtask

  task automatic do_reset(input string tag);
    act = '{0, 0};
    blk = '{0, 0};
    #2 reset = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_vec());
    check_sb(tag);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.push_back(model_vec());
    check_sb("reset_release");
    stun_seen = 0;
    pulses = '{0, 0};
  endtask

  task automatic set_positions();
    px = '{10'd100, 10'd140}; py = '{10'd200, 10'd200};
    fr = '{1'b1, 1'b0};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_positions();
    act = '{0, 0}; blk = '{0, 0}; typ = '{0, 0}; frm = '{0, 0};
    stun_seen = 0;
    pulses = '{0, 0};
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    exp_q.push_back(model_vec());
    check_sb("power_on_reset");

    // Default reach hit
    sweep(0, 12, 2'd1);
    run(20);
    check_val("reach_p2_health", p2_health, 92);
    check_val("reach_p1_health", p1_health, 100);
    check_val("reach_pulse_count", pulses[1], 1);
    check_val("reach_stun_frames", stun_seen, 20);

    // Out of range, wrong facing, then vertical range boundary
    do_reset("reset_before_range");
    px[1] = 10'd149;
    sweep(0, 12, 2'd1);
    px[1] = 10'd140;
    fr[0] = 1'b0;
    sweep(0, 12, 2'd1);
    check_val("no_hit_health", p2_health, 100);
    check_val("no_hit_pulses", pulses[1], 0);
    fr[0] = 1'b1;
    py[1] = 10'd265;
    sweep(0, 12, 2'd2);
    check_val("dy65_pulses", pulses[1], 0);
    py[1] = 10'd264;
    sweep(0, 12, 2'd2);
    check_val("dy64_health", p2_health, 88);
    set_positions();

    // Active-window boundary: frames 10..12 miss, frame 9 lands
    do_reset("reset_before_window");
    sweep(10, 12, 2'd1);
    check_val("late_frames_pulses", pulses[1], 0);
    sweep(9, 9, 2'd1);
    check_val("frame9_pulses", pulses[1], 1);

    // One hit per attack; re-attack after dropping active
    do_reset("reset_before_token");
    act[0] = 1'b1; typ[0] = 2'd1; frm[0] = 6'd5;
    run(30);
    check_val("held_attack_health", p2_health, 92);
    act[0] = 1'b0;
    frame();
    act[0] = 1'b1;
    frame();
    act[0] = 1'b0;
    check_val("reattack_health", p2_health, 84);
    check_val("reattack_pulses", pulses[1], 2);
    run(20);

    // Knockout with saturation: nine attack2 hits take P2 from 100 to 0
    do_reset("reset_before_ko");
    repeat (9) begin
      act[0] = 1'b1; typ[0] = 2'd2; frm[0] = 6'd5;
      frame();
      act[0] = 1'b0;
      run(21);
    end
    check_val("ko_p2_health", p2_health, 0);
    check_val("ko_game_over", game_over, 1);
    check_val("ko_winner", winner, 1);
    act[1] = 1'b1; typ[1] = 2'd1; frm[1] = 6'd5;
    frame();
    act[1] = 1'b0;
    frame();
    check_val("frozen_p1_health", p1_health, 100);
    check_val("frozen_p1_pulses", pulses[0], 0);

    // Trades down to a draw
    do_reset("reset_before_draw");
    repeat (7) trade(2'd2);
    trade(2'd1);
    check_val("trade_p1_health", p1_health, 8);
    check_val("trade_p2_health", p2_health, 8);
    trade(2'd1);
    check_val("draw_game_over", game_over, 1);
    check_val("draw_winner", winner, 3);
    check_val("draw_stun_both", {p1_hitstun_active, p2_hitstun_active}, 3);
    check_val("draw_health", {p1_health, p2_health}, 0);

    // Reset mid-stun
    do_reset("reset_before_midstun");
    act[0] = 1'b1; typ[0] = 2'd1; frm[0] = 6'd5;
    frame();
    act[0] = 1'b0;
    run(5);
    check_val("midstun_active", p2_hitstun_active, 1);
    do_reset("async_reset_midstun");
    check_val("after_reset_health", p2_health, 100);

`ifdef HIT_RESOLVER_BLOCK_EN
    // Blocked attack2: quarter damage, half stun
    blk[1] = 1'b1;
    act[0] = 1'b1; typ[0] = 2'd2; frm[0] = 6'd5;
    frame();
    act[0] = 1'b0;
    run(12);
    check_val("block_health", p2_health, 97);
    check_val("block_stun_frames", stun_seen, 10);
    check_val("block_pulses", pulses[1], 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/hit_resolver.md
# hit_resolver

Frame-rate hit arbiter sitting directly downstream of both `player_core` instances. It consumes each player's position, facing and attack outputs, and decides whether a strike connects. It tracks both players' health and per-player hitstun. It drives `hitstun_active` back into each `player_core`, and exposes health, hit pulses and match result to the HUD and renderer.

## Interface
Parameters:
- `POS_WIDTH`, 10, width of all position inputs
- `HEALTH_MAX`, 100, starting health; must be ≤ 255
- `HIT_RANGE_X`, 48, maximum |dx| in pixels for a connecting hit
- `HIT_RANGE_Y`, 64, maximum |dy| in pixels for a connecting hit
- `ACT_START`, 4, first `attack_frame` value of the active window
- `ACT_END`, 9, last `attack_frame` value of the active window
- `DMG_A1`, 8, damage for `attack_type` 2'd1
- `DMG_A2`, 12, damage for `attack_type` 2'd2
- `HITSTUN_FRAMES`, 20, hitstun length in SCEN ticks; must be ≥ 2

Ports:
- `clk` input 1 — system clock
- `reset` input 1 — asynchronous, active-low
- `SCEN` input 1 — one-cycle frame-tick enable
- `p1_pos_x`, `p2_pos_x` input POS_WIDTH — player x
- `p1_pos_y`, `p2_pos_y` input POS_WIDTH — player y
- `p1_face_right`, `p2_face_right` input 1 — facing
- `p1_attack_active`, `p2_attack_active` input 1 — attack in progress
- `p1_attack_type`, `p2_attack_type` input 2 — 1 = attack1, 2 = attack2, others = no hit
- `p1_attack_frame`, `p2_attack_frame` input 6 — attack frame counter
- `p1_block`, `p2_block` input 1 — guard request; used only with the configuration macro
- `p1_hitstun_active`, `p2_hitstun_active` output 1 — feed to `player_core.hitstun_active`
- `p1_health`, `p2_health` output 8 — current health
- `p1_hit_pulse`, `p2_hit_pulse` output 1 — one-clk pulse when that player is hit
- `game_over` output 1 — match ended
- `winner` output 2 — 01 = P1 won, 10 = P2 won, 11 = draw, 00 = undecided

## Operation
- All state updates occur only on clk edges where SCEN = 1, except the pulse clear.
- Per-defender FSM has three states:
  - IDLE → HITSTUN on a registered hit that leaves health > 0.
  - IDLE → KO when the hit leaves health = 0.
  - HITSTUN → IDLE when the stun counter decrements to 0.
  - KO is terminal until reset.
- Hit condition for attacker A on defender D, evaluated at each SCEN:
  - A `attack_active` = 1, and `attack_type` ∈ {1, 2}.
  - ACT_START ≤ A `attack_frame` ≤ ACT_END.
  - A's hit token is clear.
  - Facing: A `face_right` ? D_x ≥ A_x : D_x ≤ A_x.
  - |A_x − D_x| ≤ HIT_RANGE_X and |A_y − D_y| ≤ HIT_RANGE_Y, computed unsigned with POS_WIDTH+1-bit difference.
  - D is in IDLE, and `game_over` = 0.
- Hit token (per attacker):
  - Set when a hit is registered.
  - Cleared at any SCEN where A `attack_active` = 0.
  - Limits each attack to one hit. A hit rejected because D is in HITSTUN does not set the token.
- Damage subtraction saturates at 0.
- Simultaneous hits (both conditions true on the same SCEN) are both applied (trade).
- Hitstun counter:
  - Loaded with HITSTUN_FRAMES on a hit.
  - Decremented on each later SCEN.
  - `hitstun_active` = (state = HITSTUN) or (state = KO).
- `game_over` sets on the SCEN where either player enters KO and holds until reset.
  - `winner` is latched on that same edge. If both players enter KO on the same SCEN, `winner` = 11.
- After `game_over`, no hits are evaluated. Health, winner and KO state are frozen.

## Timing
- Reset values:
  - `p1_health`, `p2_health` = HEALTH_MAX.
  - Both FSMs IDLE, counters 0, tokens clear.
  - All hitstun, pulse, `game_over` and `winner` outputs = 0.
- Latency: a qualifying SCEN edge updates health, `hitstun_active` and `hit_pulse` on the same edge, so they are visible the next cycle.
- `hit_pulse` is high for exactly one clk, then clears on the following edge regardless of SCEN.
- `hitstun_active` is high for exactly HITSTUN_FRAMES SCEN ticks. It falls on the HITSTUN_FRAMES-th SCEN after the hit.
- Reset asserted mid-stun or mid-match returns all state to reset values immediately (asynchronous).

## Configuration
- Macro: `HIT_RESOLVER_BLOCK_EN`.
- Defined:
  - A hit on D with D `block` = 1 and D in IDLE is a blocked hit.
  - Blocked hit damage = dmg >> 2; stun load = HITSTUN_FRAMES >> 1.
  - `hit_pulse` still fires, and the token is still set.
- Undefined: `block` inputs are ignored, and every hit applies full damage and full stun. Port list is identical in both builds.

## Test plan
- **Default reach hit:** P1 x = 100 facing right, P2 x = 140, same y; P1 attack_type 1 through frames 0–12 → one `p2_hit_pulse`, `p2_health` 100 → 92, `p2_hitstun_active` high for exactly 20 SCEN.
- **Out of range / wrong facing:** P2 x = 149 → no hit. P1 facing left with P2 at x = 140 → no hit, health stays 100.
- **One hit per attack:** attack held active beyond stun; verify one hit only. Drop `attack_active` for one SCEN, then re-attack → second hit, health 84.
- **Trade and draw:** both at 8 health, both attack_type 1 in range on the same SCEN → both health 0, `game_over` = 1, `winner` = 11, hitstun held high.
- **Reset mid-stun:** pull `reset` low during HITSTUN → all outputs at reset values without waiting for a clk edge.
- **With `HIT_RESOLVER_BLOCK_EN`:** P2 blocks attack_type 2 → health 100 → 97, stun 10 SCEN.
